// File: rtl/signal_meter_pkg.sv
// Shared encodings for the signal meter: measurement modes and FSM states.
package signal_meter_pkg;

  typedef enum logic [1:0] {
    MODE_FREQ   = 2'b00,
    MODE_PERIOD = 2'b01,
    MODE_DUTY   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARM     = 2'b01,
    MEASURE = 2'b10,
    DONE    = 2'b11
  } state_e;

  // Reserved mode is treated as a frequency measurement.
  function automatic logic is_freq(input mode_e m);
    return (m == MODE_FREQ) || (m == MODE_RSVD);
  endfunction

endpackage

// File: rtl/signal_meter_if.sv
// Control and report bundle between a signal meter and its user.
interface signal_meter_if #(parameter int CNT_W = 32) ();
  logic             en;
  logic [1:0]       mode;
  logic             sig;
  logic [CNT_W-1:0] result;
  logic [CNT_W-1:0] aux;
  logic             valid;
  logic             overflow;
  logic             timeout;
  logic             busy;

  modport master (output en, mode, sig,
                  input  result, aux, valid, overflow, timeout, busy);
  modport slave  (input  en, mode, sig,
                  output result, aux, valid, overflow, timeout, busy);
endinterface

// File: rtl/signal_meter_sig_edge_sync.sv
// Two-flop synchroniser for the measured signal plus a registered edge detector.
module sig_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/signal_meter.sv
// Frequency / period / duty meter with saturating counters and edge timeout.
// state   | meaning
// IDLE    | not measuring; starts a run when en=1
// ARM     | period/duty: waiting for the first rise (timeout guarded)
// MEASURE | freq: counting rises over the gate; period/duty: to the next rise
// DONE    | one-cycle report (valid high); restarts directly if en=1
module signal_meter
  import signal_meter_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int GATE_CYCLES    = 100000000,
  parameter int TIMEOUT_CYCLES = 200000000
) (
  input logic           clk,
  input logic           rst,
  signal_meter_if.slave bus
);

  localparam int TMR_MAX = (GATE_CYCLES > TIMEOUT_CYCLES) ? GATE_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] GATE_LD = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LD   = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e           state, next_state;
  mode_e            mode_q, mode_in;
  logic             rise, fall, hi_phase;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] cnt, hi, cnt_n, hi_n;
  logic [CNT_W-1:0] result_q, aux_q;
  logic             ovf, ovf_n, valid_q, ovf_q, to_q;
  logic             start, arm_hit, fin, to_hit;
  logic             freq_q, duty_q, abort, tmr_zero, cnt_inc, hi_inc;

  sig_edge_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .sig  (bus.sig),
    .rise (rise),
    .fall (fall)
  );

  assign mode_in  = mode_e'(bus.mode);
  assign freq_q   = is_freq(mode_q);
  assign duty_q   = (mode_q == MODE_DUTY);
  assign abort    = !bus.en || (mode_in != mode_q);
  assign tmr_zero = (timer == '0);

  // Counters stick at all-ones; any increment attempted there flags overflow.
  assign cnt_inc = freq_q ? rise : 1'b1;
  assign hi_inc  = duty_q & hi_phase;
  assign cnt_n   = (cnt_inc && !(&cnt)) ? cnt + CNT_W'(1) : cnt;
  assign hi_n    = (hi_inc && !(&hi)) ? hi + CNT_W'(1) : hi;
  assign ovf_n   = ovf | (cnt_inc & (&cnt)) | (hi_inc & (&hi));

  always_comb begin
    next_state = state;
    start      = 1'b0;
    arm_hit    = 1'b0;
    fin        = 1'b0;
    to_hit     = 1'b0;
    case (state)
      IDLE: start = bus.en;
      ARM: begin
        if (abort) next_state = IDLE;
        else if (rise) begin
          next_state = MEASURE;
          arm_hit    = 1'b1;
        end else if (tmr_zero) begin
          next_state = DONE;
          to_hit     = 1'b1;
        end
      end
      MEASURE: begin
        if (abort) next_state = IDLE;
        else if (freq_q) begin
          if (tmr_zero) begin
            next_state = DONE;
            fin        = 1'b1;
          end
        end else if (rise) begin
          next_state = DONE;
          fin        = 1'b1;
        end else if (tmr_zero) begin
          next_state = DONE;
          to_hit     = 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
        start      = bus.en;
      end
      default: next_state = IDLE;
    endcase
    if (start) next_state = is_freq(mode_in) ? MEASURE : ARM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mode_q   <= MODE_FREQ;
      hi_phase <= 1'b0;
      timer    <= '0;
      cnt      <= '0;
      hi       <= '0;
      ovf      <= 1'b0;
      result_q <= '0;
      aux_q    <= '0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state   <= next_state;
      valid_q <= 1'b0;
      if (rise)      hi_phase <= 1'b1;
      else if (fall) hi_phase <= 1'b0;

      if (start) begin
        mode_q <= mode_in;
        timer  <= is_freq(mode_in) ? GATE_LD : TO_LD;
        cnt    <= '0;
        hi     <= '0;
        ovf    <= 1'b0;
      end else if (arm_hit) begin
        timer <= TO_LD;
        cnt   <= '0;
        hi    <= '0;
        ovf   <= 1'b0;
      end else begin
        if ((state == ARM || state == MEASURE) && !tmr_zero)
          timer <= timer - TMR_W'(1);
        if (state == MEASURE) begin
          cnt <= cnt_n;
          hi  <= hi_n;
          ovf <= ovf_n;
        end
      end

      if (fin) begin
        result_q <= duty_q ? hi_n : cnt_n;
        aux_q    <= duty_q ? cnt_n : '0;
        ovf_q    <= ovf_n;
        to_q     <= 1'b0;
        valid_q  <= 1'b1;
      end else if (to_hit) begin
        result_q <= '0;
        aux_q    <= '0;
        ovf_q    <= 1'b0;
        to_q     <= 1'b1;
        valid_q  <= 1'b1;
      end
    end
  end

  assign bus.result   = result_q;
  assign bus.aux      = aux_q;
  assign bus.valid    = valid_q;
  assign bus.overflow = ovf_q;
  assign bus.timeout  = to_q;
  assign bus.busy     = (state != IDLE);

endmodule

// File: doc/signal_meter.md
SIGNAL_METER -- requirements
Module: signal_meter

Interface
REQ-001 Parameter CNT_W, default 32: width of every measurement counter and of Result/Aux.
REQ-002 Parameter GATE_CYCLES, default 100000000: frequency gate length in Clk cycles (1 s at 100 MHz).
REQ-003 Parameter TIMEOUT_CYCLES, default 200000000: maximum Clk cycles waited for an edge in period/duty modes.
REQ-004 Clk  input  1  system clock, 100 MHz board source.
REQ-005 Rst  input  1  reset; asynchronous, active-high.
REQ-006 En  input  1  measurement enable; low aborts the measurement in progress and idles the block.
REQ-007 Mode  input  2  00 frequency, 01 period, 10 duty, 11 reserved (behaves as 00).
REQ-008 Sig  input  1  measured signal, asynchronous to Clk.
REQ-009 Result  output  CNT_W  edge count (freq), period in clocks (period), high time in clocks (duty).
REQ-010 Aux  output  CNT_W  period in clocks in duty mode; 0 in other modes.
REQ-011 Valid  output  1  one-cycle strobe when Result/Aux/flags update.
REQ-012 Overflow  output  1  a counter saturated during the reported measurement.
REQ-013 Timeout  output  1  the reported measurement ended by timeout.
REQ-014 Busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-015 Sig SHALL pass through a 2-flop synchroniser followed by an edge-detect register; rise/fall strobes lag Sig by 3 Clk cycles.
REQ-016 FSM states SHALL be IDLE, ARM, MEASURE, DONE; IDLE->ARM when En=1 (freq mode goes IDLE->MEASURE directly).
REQ-017 ARM SHALL wait for a rise strobe, then enter MEASURE with counters cleared on the same cycle.
REQ-018 Freq MEASURE SHALL last exactly GATE_CYCLES cycles counting rise strobes; a rise on the final gate cycle counts in that window.
REQ-019 Period MEASURE SHALL count Clk cycles from the arming rise to the next rise; Result = cycle count (Sig period 37 -> 37).
REQ-020 Duty MEASURE SHALL count high cycles and total cycles over one rise-to-rise period; Result = high count, Aux = total.
REQ-021 DONE SHALL last one cycle, register Result/Aux/Overflow/Timeout and pulse Valid; the FSM then returns to IDLE and restarts the next cycle if En=1.
REQ-022 Counters SHALL saturate at all-ones, never wrap; saturation sets Overflow for that report.
REQ-023 If ARM or period/duty MEASURE reaches TIMEOUT_CYCLES cycles without the awaited rise, the FSM SHALL go to DONE with Result=0, Aux=0, Timeout=1.
REQ-024 A change of Mode or En=0 outside IDLE SHALL abort to IDLE on the next cycle without Valid; the outputs keep their previous values.
REQ-025 Result, Aux, Overflow and Timeout SHALL hold between Valid strobes; Rst takes priority over all events.

Reset
REQ-026 Rst SHALL immediately force FSM=IDLE, synchroniser/edge flops=0, counters=0, Result=0, Aux=0, Valid=0, Overflow=0, Timeout=0, Busy=0.
REQ-027 After Rst deasserts, the first measurement SHALL begin on the first Clk edge with En=1.

Structure
REQ-028 Package signal_meter_pkg SHALL hold the Mode encodings and the FSM state type.
REQ-029 Sub-module sig_edge_sync SHALL contain the synchroniser and the rise/fall detection.
REQ-030 The counter and FSM logic SHALL stay in signal_meter; no division or BCD conversion belongs in this block.

Verification (CNT_W=32, GATE_CYCLES=1000, TIMEOUT_CYCLES=500 unless stated)
REQ-031 Freq: Sig period 100 clk, 50% duty -> Valid every 1001 cycles, Result=10, Aux=0.
REQ-032 Period: Sig period 37 clk -> Result=37, Overflow=0, Timeout=0.
REQ-033 Duty: Sig high 12 / low 28 -> Result=12, Aux=40.
REQ-034 Period: Sig held low -> Valid 500 cycles after ARM entry, Timeout=1, Result=0.
REQ-035 CNT_W=8, freq, 300 rises per gate -> Result=255, Overflow=1.
REQ-036 Rst or a Mode change mid-MEASURE -> no Valid for the aborted run; after Rst all outputs are 0 before the next Clk edge.
